fifo_rd_stream: RTL

Read-side drain engine for the team's asynchronous FIFO, running entirely in the FIFO read clock domain. Pops words through the FIFO's `rinc`/`rempty`/`rdata` port, buffers them in a 2-entry output skid buffer, and presents them as a valid/ready stream framed into fixed-length packets with an `m_last` marker. Adds enable/drain control so packets are never truncated, plus packet counting and inter-beat gap detection.

---
 rtl/fifo_rd_stream.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side drain engine for the asynchronous FIFO. Lives entirely in the read
// clock domain: pops words from the FIFO, holds them in a 2-entry skid buffer and
// presents them as a valid/ready stream framed into PKT_LEN-word packets.
// Enable/drain control guarantees packets are never truncated on the output side.
module fifo_rd_stream #(
  parameter int unsigned DSIZE   = 8,
  parameter int unsigned PKT_LEN = 16,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned GAP_MAX = 64
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             en,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic             gap_err
);

  localparam int unsigned IdxW = $clog2(PKT_LEN);
  localparam int unsigned GapW = $clog2(GAP_MAX + 1);

  localparam logic [IdxW-1:0] IdxLast  = IdxW'(PKT_LEN - 1);
  localparam logic [GapW-1:0] GapLimit = GapW'(GAP_MAX);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       occ_q, occ_d;
  logic [DSIZE-1:0] buf0_q, buf0_d;   // head entry
  logic [DSIZE-1:0] buf1_q, buf1_d;   // second entry, only meaningful when occ_q == 2
  logic [IdxW-1:0]  rd_idx_q, rd_idx_d;
  logic [IdxW-1:0]  beat_idx_q, beat_idx_d;
  logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic             gap_err_q, gap_err_d;

  logic             pop;
  logic             valid;
  logic             accept;
  logic             last_beat;
  logic             drained;

  // Handshakes: pop depends only on registered state and rempty, never on m_ready.
  always_comb begin
    pop = 1'b0;
    if (!rrst && !rempty && (occ_q != 2'd2)) begin
      pop = (state_q == StRun) || ((state_q == StDrain) && (rd_idx_q != '0));
    end
    valid     = !rrst && (occ_q != 2'd0);
    last_beat = valid && (beat_idx_q == IdxLast);
    accept    = valid && m_ready;
  end

  // Skid buffer: head shifts out on accept, popped word lands at the tail.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_q;
    case ({pop, accept})
      2'b10: begin
        occ_d = occ_q + 2'd1;
        if (occ_q == 2'd0) begin
          buf0_d = rdata;
        end else begin
          buf1_d = rdata;
        end
      end
      2'b01: begin
        occ_d  = occ_q - 2'd1;
        buf0_d = buf1_q;
      end
      // Both at once only happens with occ_q == 1: the new word replaces the head.
      2'b11: begin
        buf0_d = rdata;
      end
      default: ;
    endcase
  end

  // Packet position counters for the pop side and the stream side.
  always_comb begin
    rd_idx_d   = rd_idx_q;
    beat_idx_d = beat_idx_q;
    pkt_cnt_d  = pkt_cnt_q;
    if (pop) begin
      rd_idx_d = (rd_idx_q == IdxLast) ? '0 : rd_idx_q + IdxW'(1);
    end
    if (accept) begin
      beat_idx_d = (beat_idx_q == IdxLast) ? '0 : beat_idx_q + IdxW'(1);
      if (last_beat) begin
        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
      end
    end
  end

  // Mid-packet starvation detector; backpressure never counts as a gap.
  always_comb begin
    gap_cnt_d = gap_cnt_q;
    if (valid || (beat_idx_q == '0)) begin
      gap_cnt_d = '0;
    end else if (gap_cnt_q != GapLimit) begin
      gap_cnt_d = gap_cnt_q + GapW'(1);
    end
    gap_err_d = gap_err_q || (gap_cnt_d == GapLimit);
  end

  // Run/drain control. Idle is judged on the post-edge counters so the engine
  // drops busy right after the final beat of a packet is accepted.
  always_comb begin
    state_d = state_q;
    drained = (rd_idx_d == '0) && (beat_idx_d == '0) && (occ_d == 2'd0);
    case (state_q)
      StIdle: begin
        if (en) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!en) begin
          state_d = drained ? StIdle : StDrain;
        end
      end
      StDrain: begin
        if (en) begin
          state_d = StRun;
        end else if (drained) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; buffered words are discarded.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q    <= StIdle;
      occ_q      <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      rd_idx_q   <= '0;
      beat_idx_q <= '0;
      gap_cnt_q  <= '0;
      pkt_cnt_q  <= '0;
      gap_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      rd_idx_q   <= rd_idx_d;
      beat_idx_q <= beat_idx_d;
      gap_cnt_q  <= gap_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      gap_err_q  <= gap_err_d;
    end
  end

  // Outputs are forced quiet while reset is asserted.
  always_comb begin
    rinc    = pop;
    m_valid = valid;
    m_last  = last_beat;
    m_data  = rrst ? '0 : buf0_q;
    busy    = !rrst && (state_q != StIdle);
    pkt_cnt = pkt_cnt_q;
    gap_err = gap_err_q;
  end

endmodule
